// File: rtl/snes_button_events_if.sv
// Bus bundle for snes_button_events: raw button word and poll strobe in,
// debounced levels, event stream with valid/ready and the sticky overflow flag out.
interface snes_button_events_if;
   logic [15:0] buttons;
   logic        frame_tick;
   logic [15:0] held;
   logic        evt_valid;
   logic [4:0]  evt_code;
   logic        evt_ready;
   logic        overflow;

   // master: the event source (snes_button_events itself)
   modport master (
      input  buttons, frame_tick, evt_ready,
      output held, evt_valid, evt_code, overflow
   );

   // slave: the receiver/consumer side wrapped around the event source
   modport slave (
      output buttons, frame_tick, evt_ready,
      input  held, evt_valid, evt_code, overflow
   );
endinterface

// File: rtl/snes_button_events.sv
// Debounces the SNES button word per poll frame and queues press/release events in a FIFO.
// Release events are queued only when SNES_EVT_RELEASE_EN is defined; otherwise presses only.
module snes_button_events #(
   parameter int DEBOUNCE   = 2,
   parameter int FIFO_DEPTH = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   snes_button_events_if.master bus
);
   localparam int         AW = $clog2(FIFO_DEPTH);
   localparam logic [3:0] DB = 4'(DEBOUNCE);
   localparam logic [AW:0] FULL_COUNT = (AW+1)'(FIFO_DEPTH);

   logic [15:0] held_reg, held_next;
   logic [15:0] pend_reg, pend_next;
   logic [15:0] flip;
   logic [15:0] pend_set;
   logic [15:0] collide;
   logic [15:0] push_hot;
   logic        overflow_reg, overflow_next;

   logic        scan_any;
   logic [3:0]  scan_idx;
   logic        push, pop, full;
   logic [4:0]  push_code;

   logic [4:0]    mem [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr_reg, wr_ptr_next;
   logic [AW-1:0] rd_ptr_reg, rd_ptr_next;
   logic [AW:0]   count_reg, count_next;

   genvar gi;
   generate
      for (gi = 0; gi < 16; gi++) begin : g_btn
         logic [3:0] cnt_reg, cnt_next;
         logic       differ, reach;

         assign differ = bus.buttons[gi] ^ held_reg[gi];
         assign reach  = (cnt_reg + 4'd1) == DB;
         assign flip[gi] = bus.frame_tick & differ & reach;

         // agreement or a completed flip both restart the run of differing samples
         assign cnt_next = (!bus.frame_tick)  ? cnt_reg :
                           (!differ || reach) ? 4'd0    : cnt_reg + 4'd1;

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) cnt_reg <= 4'd0;
            else        cnt_reg <= cnt_next;
         end

`ifdef SNES_EVT_RELEASE_EN
         assign pend_set[gi] = flip[gi];
`else
         // only a flip from 0 to 1 is worth an event
         assign pend_set[gi] = flip[gi] & ~held_reg[gi];
`endif
         // an unpushed pending event overwritten by a new one is lost
         assign collide[gi] = pend_set[gi] & pend_reg[gi] & ~push_hot[gi];
      end
   endgenerate

   always_comb begin
      scan_any = |pend_reg;
      scan_idx = 4'd0;
      for (int i = 15; i >= 0; i--) begin
         if (pend_reg[i]) scan_idx = 4'(i);
      end
   end

   // full is judged on the pre-pop count, so a pop never frees space for the same cycle
   assign full      = (count_reg == FULL_COUNT);
   assign pop       = (count_reg != '0) & bus.evt_ready;
   assign push      = scan_any & ~full;
   assign push_hot  = push ? (16'd1 << scan_idx) : 16'd0;
   assign push_code = {held_reg[scan_idx], scan_idx};

   assign held_next     = held_reg ^ flip;
   assign pend_next     = (pend_reg & ~push_hot) | pend_set;
   assign overflow_next = overflow_reg | (|collide);

   assign wr_ptr_next = push ? wr_ptr_reg + AW'(1) : wr_ptr_reg;
   assign rd_ptr_next = pop  ? rd_ptr_reg + AW'(1) : rd_ptr_reg;
   assign count_next  = count_reg + (AW+1)'(push) - (AW+1)'(pop);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         held_reg     <= 16'h0000;
         pend_reg     <= 16'h0000;
         overflow_reg <= 1'b0;
         wr_ptr_reg   <= '0;
         rd_ptr_reg   <= '0;
         count_reg    <= '0;
      end else begin
         held_reg     <= held_next;
         pend_reg     <= pend_next;
         overflow_reg <= overflow_next;
         wr_ptr_reg   <= wr_ptr_next;
         rd_ptr_reg   <= rd_ptr_next;
         count_reg    <= count_next;
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr_reg] <= push_code;
   end

   assign bus.held      = held_reg;
   assign bus.overflow  = overflow_reg;
   assign bus.evt_valid = (count_reg != '0);
   // storage is not reset, so the head is masked until something is queued
   assign bus.evt_code  = (count_reg != '0) ? mem[rd_ptr_reg] : 5'h00;
endmodule
